// File: rtl/position_integrator.sv
// Odometry integration stage: converts unsigned travel steps with direction
// and cardinal heading into signed deltas and accumulates them into
// saturating (or wrapping) signed X/Y position registers.
module position_integrator #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [WIDTH-1:0] step_mag,
  input  logic             step_dir,
  input  logic [1:0]       heading,
  input  logic             zero_pos,
  output logic [WIDTH-1:0] pos_x,
  output logic [WIDTH-1:0] pos_y,
  output logic             upd_done,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] POS_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;

  logic [WIDTH-1:0] r_mag;
  logic             r_dir;
  logic [1:0]       r_head;
  logic [WIDTH-1:0] r_delta;
  logic [WIDTH-1:0] r_pos_x;
  logic [WIDTH-1:0] r_pos_y;
  logic             r_upd_done;
  logic             r_ovf;
  logic             r_ready;

  logic             w_neg;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH:0]   w_sum;
  logic             w_sum_ovf;
  logic [WIDTH-1:0] w_new;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; zero_pos aborts any in-flight step
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (step_valid) w_state_nx = CONV;
      CONV:    w_state_nx = ACC;
      ACC:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (zero_pos) w_state_nx = IDLE;
  end

  // Delta sign, target-axis sum and overflow/saturation resolution
  always_comb begin
    w_neg     = r_dir ^ r_head[1];
    w_target  = r_head[0] ? r_pos_x : r_pos_y;
    w_sum     = {w_target[WIDTH-1], w_target} + {r_delta[WIDTH-1], r_delta};
    w_sum_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    w_new     = w_sum[WIDTH-1:0];
    if (w_sum_ovf && SAT_EN) begin
      w_new = w_sum[WIDTH] ? POS_MIN : MAG_MAX;
    end
  end

  // Datapath registers: step capture, delta conversion, accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag      <= '0;
      r_dir      <= 1'b0;
      r_head     <= 2'd0;
      r_delta    <= '0;
      r_pos_x    <= '0;
      r_pos_y    <= '0;
      r_upd_done <= 1'b0;
      r_ovf      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_ready    <= (w_state_nx == IDLE);
      r_upd_done <= 1'b0;
      if (zero_pos) begin
        r_pos_x <= '0;
        r_pos_y <= '0;
        r_ovf   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (step_valid) begin
              r_mag  <= (step_mag > MAG_MAX) ? MAG_MAX : step_mag;
              r_dir  <= step_dir;
              r_head <= heading;
            end
          end
          CONV: begin
            r_delta <= w_neg ? (~r_mag + WIDTH'(1)) : r_mag;
          end
          ACC: begin
            if (r_head[0]) r_pos_x <= w_new;
            else           r_pos_y <= w_new;
            if (w_sum_ovf && SAT_EN) r_ovf <= 1'b1;
            r_upd_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign step_ready = r_ready;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign upd_done   = r_upd_done;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_position_integrator.sv
// Self-checking bench for position_integrator: one saturating and one
// wrapping instance share stimulus and are compared every cycle against a
// transaction-level arithmetic model.
module tb_position_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_valid;
  logic [15:0] step_mag;
  logic        step_dir;
  logic [1:0]  heading;
  logic        zero_pos;

  logic        rdy0, rdy1, upd0, upd1, ovf0, ovf1;
  logic [15:0] px0, py0, px1, py1;

  int n_cmp = 0;
  int n_err = 0;

  // model: [0] saturating instance, [1] wrapping instance
  int m_x[2];
  int m_y[2];
  int m_ovf[2];
  int m_upd;
  int p_act, p_left, p_mag, p_dir, p_head;

  always #5 clk = ~clk;

  position_integrator #(.WIDTH(16), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(rdy0),
    .step_mag(step_mag), .step_dir(step_dir), .heading(heading),
    .zero_pos(zero_pos), .pos_x(px0), .pos_y(py0), .upd_done(upd0), .ovf(ovf0)
  );

  position_integrator #(.WIDTH(16), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(rdy1),
    .step_mag(step_mag), .step_dir(step_dir), .heading(heading),
    .zero_pos(zero_pos), .pos_x(px1), .pos_y(py1), .upd_done(upd1), .ovf(ovf1)
  );

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Apply one accepted step to instance i using plain integer arithmetic
  task automatic model_apply(input int i);
    int m, d, s;
    m = (p_mag > 32767) ? 32767 : p_mag;
    d = ((p_dir ^ (p_head >> 1)) & 1) != 0 ? -m : m;
    s = ((p_head & 1) != 0) ? m_x[i] + d : m_y[i] + d;
    if (i == 0) begin
      if (s > 32767)       begin s = 32767;  m_ovf[i] = 1; end
      else if (s < -32768) begin s = -32768; m_ovf[i] = 1; end
    end else begin
      s = ((s + 98304) % 65536) - 32768;
    end
    if ((p_head & 1) != 0) m_x[i] = s;
    else                   m_y[i] = s;
  endtask

  // Model behaviour at one rising edge given the inputs sampled there
  task automatic model_edge();
    m_upd = 0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; m_ovf[i] = 0; end
      p_act = 0;
    end else if (zero_pos) begin
      for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; m_ovf[i] = 0; end
      p_act = 0;
    end else if (p_act != 0) begin
      if (p_left == 1) begin
        model_apply(0);
        model_apply(1);
        m_upd = 1;
        p_act = 0;
      end else begin
        p_left--;
      end
    end else if (step_valid) begin
      p_act  = 1;
      p_left = 2;
      p_mag  = int'(step_mag);
      p_dir  = int'(step_dir);
      p_head = int'(heading);
    end
  endtask

  task automatic check_all();
    check("ready_sat",  int'(rdy0), (p_act == 0) ? 1 : 0);
    check("ready_wrap", int'(rdy1), (p_act == 0) ? 1 : 0);
    check("upd_sat",    int'(upd0), m_upd);
    check("upd_wrap",   int'(upd1), m_upd);
    check("x_sat",      sx(px0), m_x[0]);
    check("y_sat",      sx(py0), m_y[0]);
    check("x_wrap",     sx(px1), m_x[1]);
    check("y_wrap",     sx(py1), m_y[1]);
    check("ovf_sat",    int'(ovf0), m_ovf[0]);
    check("ovf_wrap",   int'(ovf1), m_ovf[1]);
  endtask

  task automatic tick(input logic r, input logic v, input logic [15:0] mag,
                      input logic d, input logic [1:0] h, input logic z);
    @(negedge clk);
    rst = r; step_valid = v; step_mag = mag; step_dir = d; heading = h; zero_pos = z;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // One step followed by two busy cycles carrying ignored garbage
  task automatic step(input logic [15:0] mag, input logic d, input logic [1:0] h);
    tick(1'b0, 1'b1, mag, d, h, 1'b0);
    for (int k = 0; k < 2; k++)
      tick(1'b0, 1'b1, 16'($urandom), 1'($urandom), 2'($urandom), 1'b0);
  endtask

  initial begin
    rst = 1'b1; step_valid = 1'b0; step_mag = '0; step_dir = 1'b0;
    heading = 2'd0; zero_pos = 1'b0;
    p_act = 0; p_left = 0; p_mag = 0; p_dir = 0; p_head = 0; m_upd = 0;
    for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; m_ovf[i] = 0; end

    tick(1'b1, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
    tick(1'b1, 1'b1, 16'h1234, 1'b0, 2'd1, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);

    // basic headings and directions
    step(16'h0010, 1'b0, 2'd1);
    check("dir_e_fwd", sx(px0), 16);
    step(16'h0030, 1'b1, 2'd1);
    check("dir_e_rev", sx(px0), -32);
    step(16'h0005, 1'b0, 2'd3);
    check("dir_w_fwd", sx(px0), -37);
    step(16'h0005, 1'b1, 2'd2);
    check("dir_s_rev", sx(py0), 5);
    check("x_hold",    sx(px0), -37);
    step(16'h0000, 1'b1, 2'd0);
    check("mag_zero",  sx(py0), 5);

    // saturation and clamp on Y
    tick(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
    step(16'h7FF0, 1'b0, 2'd0);
    step(16'h0020, 1'b0, 2'd0);
    check("sat_pos",   sx(py0), 32767);
    check("sat_ovf",   int'(ovf0), 1);
    check("wrap_pos",  sx(py1), -32752);
    step(16'hFFFF, 1'b1, 2'd0);
    check("clamp_sat", sx(py0), 0);
    check("ovf_stick", int'(ovf0), 1);

    // wrap at X boundary
    tick(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
    step(16'h7FFF, 1'b0, 2'd1);
    step(16'h0001, 1'b0, 2'd1);
    check("wrap_x",    sx(px1), -32768);
    check("wrap_novf", int'(ovf1), 0);

    // zero_pos during CONV aborts the step
    tick(1'b0, 1'b1, 16'h0100, 1'b0, 2'd1, 1'b0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b1);
    check("abort_rdy", int'(rdy0), 1);
    check("abort_x",   sx(px0), 0);
    tick(1'b0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0);
    check("abort_upd", int'(upd0), 0);
    tick(1'b0, 1'b1, 16'h0002, 1'b0, 2'd0, 1'b1);
    step(16'h0007, 1'b0, 2'd0);
    check("after_abort", sx(py0), 7);

    // held valid with changing magnitude
    for (int k = 0; k < 30; k++)
      tick(1'b0, 1'b1, 16'($urandom_range(0, 255)), 1'($urandom), 2'($urandom), 1'b0);

    // random stress
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] mg;
      mg = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
      tick(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7), mg,
           1'($urandom), 2'($urandom), 1'($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/position_integrator.md
Name: position_integrator

Overview:
Odometry integration stage for the Position subsystem. Accepts unsigned 16-bit travel magnitudes with a direction flag and a cardinal heading. Converts each step to a signed two's-complement delta (negation is ~mag + 1) and accumulates it into saturating signed X/Y position registers. Feeds the navigation logic and sits between the wheel-distance source and the map/boundary checks.

Parameters:
WIDTH, 16, width of step magnitude, delta and position registers
SAT_EN, 1, 1 = saturate position on signed overflow; 0 = wrap modulo 2^WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
step_valid  input  1  step transfer request
step_ready  output  1  block can accept a step this cycle
step_mag  input  WIDTH  unsigned travel magnitude
step_dir  input  1  0 = forward, 1 = reverse
heading  input  2  0 = +Y (N), 1 = +X (E), 2 = -Y (S), 3 = -X (W)
zero_pos  input  1  synchronous clear of position and overflow flag
pos_x  output  WIDTH  signed X position
pos_y  output  WIDTH  signed Y position
upd_done  output  1  one-cycle pulse: position register updated
ovf  output  1  sticky flag: a saturation event occurred

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; pos_x=pos_y=0; ovf=0; upd_done=0; step_ready=1 after the edge. Any in-flight step is discarded.
- States: IDLE, CONV, ACC.
- IDLE: step_ready=1. On step_valid&&step_ready at edge E0:
  - Latch mag, dir and heading.
  - Clamp mag to 2^(WIDTH-1)-1 (0x7FFF) if larger.
  - Go to CONV.
- CONV: step_ready=0.
  - neg = step_dir XOR heading[1].
  - At edge E1 register delta = neg ? (~mag + 1) : mag, truncated to WIDTH bits.
  - A mag of 0 yields delta 0 in both cases.
  - Go to ACC.
- ACC: step_ready=0.
  - Target axis is X when heading[0]=1, otherwise Y.
  - sum = sign-extended target + sign-extended delta, computed at WIDTH+1 bits.
  - Overflow exists when bit WIDTH differs from bit WIDTH-1 of sum.
  - SAT_EN=1 on overflow: target = 0x7FFF (positive overflow) or 0x8000 (negative overflow), and ovf is set.
  - SAT_EN=0 on overflow: target = low WIDTH bits of sum, ovf unchanged.
  - At edge E2 the target is written, upd_done=1 for the following cycle only, and the state returns to IDLE.
- Latency: position visible 2 edges after acceptance. Throughput is 1 step per 3 cycles. step_ready is high again in the cycle after E2, together with upd_done.
- Only the target axis changes; the other axis holds.
- zero_pos=1 at any edge, in any state:
  - pos_x=pos_y=0, ovf=0, state→IDLE, in-flight step dropped, no upd_done.
  - Priority: rst > zero_pos > normal operation.
  - If zero_pos and step_valid coincide in IDLE, the step is not accepted.
- step_valid while busy is ignored. The source holds the step until it sees step_ready.
- ovf clears only on rst or zero_pos.
- Inputs are sampled only at the accepting edge. Changes afterwards do not affect the in-flight step.

Test Plan:
- Reset, then step mag=0x0010, dir=0, heading=E → pos_x=0x0010, pos_y=0, upd_done one cycle exactly 2 edges after acceptance, step_ready low 2 cycles.
- From pos_x=0x0010: step mag=0x0030, dir=1, heading=E → pos_x=0xFFE0 (-32). Then mag=0x0005, dir=0, heading=W → pos_x=0xFFDB (-37). Then mag=0x0005, dir=1, heading=S → pos_y=0x0005.
- SAT_EN=1, pos_y=0x7FF0: step mag=0x0020, heading=N → pos_y=0x7FFF, ovf=1. Then step mag=0xFFFF, dir=1, heading=N → mag clamped to 0x7FFF, pos_y=0x0000, ovf stays 1.
- SAT_EN=0, pos_x=0x7FFF: step mag=1, heading=E → pos_x=0x8000, ovf=0.
- Assert zero_pos during CONV of an in-flight step → pos cleared, ovf=0, no upd_done, step_ready=1 next cycle. A new step is then accepted normally.
- Hold step_valid continuously with changing step_mag → exactly one acceptance per 3 cycles. Each accepted value is integrated once, with no duplicates or drops.
